cpu_dma_arbiter: RTL and testbench



---
 rtl/cpu_dma_arbiter_pkg.sv | 32 +++
 rtl/cpu_dma_arbiter_counters.sv | 65 ++++++
 rtl/cpu_dma_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cpu_dma_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dma_arbiter_pkg.sv
// Shared types and constants for the 6502C / DMA bus arbiter.
// Holds the state encoding, the memory bus payload and the parameter range check.
package cpu_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALT = 2'd1,
        ST_DMA  = 2'd2
    } arb_state_e;

    localparam logic RW_READ = 1'b1;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned BURST_W  = 8;
    localparam int unsigned GAP_W    = 4;
    localparam int unsigned WR_W     = 8;
    localparam int unsigned STOLEN_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    // Legal ranges: burst 1..255, gap 0..15, write tolerance must leave room in the write counter.
    function automatic bit params_ok(int unsigned max_burst, int unsigned min_gap,
                                     int unsigned max_writes);
        return (max_burst >= 1) && (max_burst <= 255) && (min_gap <= 15) && (max_writes <= 254);
    endfunction

endpackage

// File: rtl/cpu_dma_arbiter_counters.sv
// Burst, gap, halt-write and stolen-cycle counters for the arbiter.
// Pure datapath: every load/clear/step enable comes from the arbiter FSM.
module arb_counters
    import cpu_dma_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                burst_clr,
    input  logic                burst_inc,
    input  logic                gap_load,
    input  logic                gap_clr,
    input  logic                gap_dec,
    input  logic [GAP_W-1:0]    gap_value,
    input  logic                wr_clr,
    input  logic                wr_inc,
    input  logic                stolen_inc,
    output logic [BURST_W-1:0]  burst,
    output logic [GAP_W-1:0]    gap,
    output logic [WR_W-1:0]     wr_cnt,
    output logic [STOLEN_W-1:0] stolen_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst <= '0;
        end else if (burst_clr) begin
            burst <= '0;
        end else if (burst_inc) begin
            burst <= burst + BURST_W'(1);
        end
    end

    // Gap counter floors at zero while the CPU owns the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
        end else if (gap_load) begin
            gap <= gap_value;
        end else if (gap_clr) begin
            gap <= '0;
        end else if (gap_dec && (gap != '0)) begin
            gap <= gap - GAP_W'(1);
        end
    end

    // Write count saturates so a long stall cannot wrap it back under the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (wr_clr) begin
            wr_cnt <= '0;
        end else if (wr_inc && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + WR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stolen_cnt <= '0;
        end else if (stolen_inc) begin
            stolen_cnt <= stolen_cnt + STOLEN_W'(1);
        end
    end

endmodule

// File: rtl/cpu_dma_arbiter.sv
// Shared memory bus arbiter between the 6502C core and a DMA read master.
// Halts the CPU through RDY, waits out in-flight writes, runs a bounded burst, then returns the bus.
module cpu_dma_arbiter
    import cpu_dma_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned MIN_GAP    = 1,
    parameter int unsigned MAX_WRITES = 3
) (
    input  logic                phi2,
    input  logic                RES,
    input  logic [ADDR_W-1:0]   cpu_AB,
    input  logic                cpu_RW,
    input  logic [DATA_W-1:0]   cpu_DO,
    input  logic [DATA_W-1:0]   mem_DI,
    input  logic                dma_req,
    input  logic [ADDR_W-1:0]   dma_AB,
    output logic                RDY,
    output logic [ADDR_W-1:0]   mem_AB,
    output logic                mem_RW,
    output logic [DATA_W-1:0]   mem_DO,
    output logic                dma_ack,
    output logic [DATA_W-1:0]   dma_DI,
    output logic                dma_busy,
    output logic                halt_err,
    output logic [STOLEN_W-1:0] stolen_cnt
);

    if (!params_ok(MAX_BURST, MIN_GAP, MAX_WRITES)) begin : g_bad_params
        $error("cpu_dma_arbiter: MAX_BURST, MIN_GAP or MAX_WRITES out of range");
    end

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT   = GAP_W'(MIN_GAP);
    localparam logic [WR_W-1:0]    WR_LIMIT   = WR_W'(MAX_WRITES);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                rdy_d;
    logic                halt_err_d;
    logic                burst_clr;
    logic                burst_inc;
    logic                gap_load;
    logic                gap_clr;
    logic                gap_dec;
    logic                wr_clr;
    logic                wr_inc;
    logic                stolen_inc;
    logic [BURST_W-1:0]  burst;
    logic [GAP_W-1:0]    gap;
    logic [WR_W-1:0]     wr_cnt;
    bus_req_t            mem_bus;

    arb_counters u_counters (
        .clk        (phi2),
        .rst        (RES),
        .burst_clr  (burst_clr),
        .burst_inc  (burst_inc),
        .gap_load   (gap_load),
        .gap_clr    (gap_clr),
        .gap_dec    (gap_dec),
        .gap_value  (GAP_INIT),
        .wr_clr     (wr_clr),
        .wr_inc     (wr_inc),
        .stolen_inc (stolen_inc),
        .burst      (burst),
        .gap        (gap),
        .wr_cnt     (wr_cnt),
        .stolen_cnt (stolen_cnt)
    );

    always_ff @(posedge phi2 or posedge RES) begin
        if (RES) begin
            state_q  <= ST_IDLE;
            RDY      <= 1'b1;
            halt_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            RDY      <= rdy_d;
            halt_err <= halt_err_d;
        end
    end

    // Next state and counter enables. The IDLE cycle in progress counts toward the gap,
    // so a request may halt the CPU once the gap is down to its last cycle.
    always_comb begin
        state_d    = state_q;
        rdy_d      = RDY;
        halt_err_d = halt_err;
        burst_clr  = 1'b0;
        burst_inc  = 1'b0;
        gap_load   = 1'b0;
        gap_clr    = 1'b0;
        gap_dec    = 1'b0;
        wr_clr     = 1'b0;
        wr_inc     = 1'b0;
        stolen_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gap_dec = 1'b1;
                if (dma_req && (gap <= GAP_W'(1))) begin
                    state_d = ST_HALT;
                    rdy_d   = 1'b0;
                    wr_clr  = 1'b1;
                end
            end
            ST_HALT: begin
                if (!dma_req) begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    gap_clr = 1'b1;
                end else if (cpu_RW == RW_READ) begin
                    state_d   = ST_DMA;
                    burst_clr = 1'b1;
                end else begin
                    wr_inc = 1'b1;
                    if (wr_cnt == WR_LIMIT) begin
                        halt_err_d = 1'b1;
                    end
                end
            end
            ST_DMA: begin
                burst_inc  = 1'b1;
                stolen_inc = 1'b1;
                if (!dma_req || (burst == BURST_LAST)) begin
                    state_d  = ST_IDLE;
                    rdy_d    = 1'b1;
                    gap_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge phi2 or posedge RES) begin
        if (RES) begin
            dma_DI <= '0;
        end else if (state_q == ST_DMA) begin
            dma_DI <= mem_DI;
        end
    end

    assign dma_busy = (state_q == ST_DMA);
    assign dma_ack  = dma_busy;

    // Bus mux follows state directly so an async reset hands the bus back at once.
    always_comb begin
        if (dma_busy) begin
            mem_bus.addr = dma_AB;
            mem_bus.rw   = RW_READ;
            mem_bus.data = '0;
        end else begin
            mem_bus.addr = cpu_AB;
            mem_bus.rw   = cpu_RW;
            mem_bus.data = cpu_DO;
        end
    end

    assign mem_AB = mem_bus.addr;
    assign mem_RW = mem_bus.rw;
    assign mem_DO = mem_bus.data;

endmodule

// File: tb/tb_cpu_dma_arbiter.sv
// Self-checking bench for cpu_dma_arbiter: vector table, directed corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_cpu_dma_arbiter;

    localparam int MAX_BURST  = 8;
    localparam int MIN_GAP    = 1;
    localparam int MAX_WRITES = 3;

    logic        phi2 = 1'b0;
    logic        RES;
    logic [15:0] cpu_AB;
    logic        cpu_RW;
    logic [7:0]  cpu_DO;
    logic [7:0]  mem_DI;
    logic        dma_req;
    logic [15:0] dma_AB;
    logic        RDY;
    logic [15:0] mem_AB;
    logic        mem_RW;
    logic [7:0]  mem_DO;
    logic        dma_ack;
    logic [7:0]  dma_DI;
    logic        dma_busy;
    logic        halt_err;
    logic [15:0] stolen_cnt;

    cpu_dma_arbiter #(
        .MAX_BURST  (MAX_BURST),
        .MIN_GAP    (MIN_GAP),
        .MAX_WRITES (MAX_WRITES)
    ) dut (
        .phi2       (phi2),
        .RES        (RES),
        .cpu_AB     (cpu_AB),
        .cpu_RW     (cpu_RW),
        .cpu_DO     (cpu_DO),
        .mem_DI     (mem_DI),
        .dma_req    (dma_req),
        .dma_AB     (dma_AB),
        .RDY        (RDY),
        .mem_AB     (mem_AB),
        .mem_RW     (mem_RW),
        .mem_DO     (mem_DO),
        .dma_ack    (dma_ack),
        .dma_DI     (dma_DI),
        .dma_busy   (dma_busy),
        .halt_err   (halt_err),
        .stolen_cnt (stolen_cnt)
    );

    always #5 phi2 = ~phi2;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who holds the bus, how long it has held it, and what it has seen.
    bit          m_rdy;
    bit          m_own;
    bit          m_err;
    int          m_run;
    int          m_gap;
    int          m_writes;
    int unsigned m_stolen;
    logic [7:0]  m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_rdy = 1'b1; m_own = 1'b0; m_err = 1'b0; m_run = 0;
        m_gap = 0; m_writes = 0; m_stolen = 0; m_last = 8'h00;
    endtask

    task automatic m_step();
        if (m_own) begin
            m_last   = mem_DI;
            m_stolen = (m_stolen + 1) % 65536;
            m_run++;
            if (!dma_req || m_run == MAX_BURST) begin
                m_own = 1'b0; m_rdy = 1'b1; m_gap = MIN_GAP;
            end
        end else if (!m_rdy) begin
            if (!dma_req) begin
                m_rdy = 1'b1; m_gap = 0;
            end else if (cpu_RW) begin
                m_own = 1'b1; m_run = 0;
            end else begin
                m_writes++;
                if (m_writes > MAX_WRITES) m_err = 1'b1;
            end
        end else begin
            if (dma_req && m_gap <= 1) begin
                m_rdy = 1'b0; m_writes = 0;
            end
            if (m_gap > 0) m_gap--;
        end
    endtask

    task automatic check_outputs();
        chk("RDY",        32'(RDY),        32'(m_rdy));
        chk("dma_busy",   32'(dma_busy),   32'(m_own));
        chk("dma_ack",    32'(dma_ack),    32'(m_own));
        chk("mem_AB",     32'(mem_AB),     m_own ? 32'(dma_AB) : 32'(cpu_AB));
        chk("mem_RW",     32'(mem_RW),     m_own ? 32'd1 : 32'(cpu_RW));
        chk("mem_DO",     32'(mem_DO),     m_own ? 32'd0 : 32'(cpu_DO));
        chk("dma_DI",     32'(dma_DI),     32'(m_last));
        chk("halt_err",   32'(halt_err),   32'(m_err));
        chk("stolen_cnt", 32'(stolen_cnt), m_stolen);
    endtask

    task automatic drive(input logic req, input logic rw, input logic [15:0] cab,
                         input logic [7:0] cdo, input logic [15:0] dab, input logic [7:0] di);
        dma_req = req; cpu_RW = rw; cpu_AB = cab; cpu_DO = cdo; dma_AB = dab; mem_DI = di;
    endtask

    task automatic tick();
        @(posedge phi2);
        m_step();
        #1;
    endtask

    task automatic cycle(input logic req, input logic rw, input logic [15:0] cab,
                         input logic [7:0] cdo, input logic [15:0] dab, input logic [7:0] di);
        drive(req, rw, cab, cdo, dab, di);
        #4;
        check_outputs();
        tick();
    endtask

    typedef struct {
        logic        req;
        logic        rw;
        logic [15:0] cab;
        logic [15:0] dab;
        logic [7:0]  di;
        logic        e_rdy;
        logic        e_busy;
        logic [15:0] e_ab;
        logic [7:0]  e_ddi;
        logic [15:0] e_stolen;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_ones;
        int busy_cycles;
        int unsigned base;
        logic [15:0] wa;

        // Request, halt, one CPU read, four DMA reads, release.
        tbl[0] = '{1'b0, 1'b1, 16'h1234, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 16'h1234, 16'h3C00, 8'h00, 1'b1, 1'b0, 16'h1234, 8'h00, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 16'h1235, 16'h3C00, 8'h00, 1'b0, 1'b0, 16'h1235, 8'h00, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 16'h1235, 16'h3C00, 8'hA0, 1'b0, 1'b1, 16'h3C00, 8'h00, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 16'h1235, 16'h3C01, 8'hA1, 1'b0, 1'b1, 16'h3C01, 8'hA0, 16'd1};
        tbl[5] = '{1'b1, 1'b1, 16'h1235, 16'h3C02, 8'hA2, 1'b0, 1'b1, 16'h3C02, 8'hA1, 16'd2};
        tbl[6] = '{1'b0, 1'b1, 16'h1235, 16'h3C03, 8'hA3, 1'b0, 1'b1, 16'h3C03, 8'hA2, 16'd3};
        tbl[7] = '{1'b0, 1'b1, 16'h1235, 16'h3C03, 8'h00, 1'b1, 1'b0, 16'h1235, 8'hA3, 16'd4};

        RES = 1'b1;
        drive(1'b0, 1'b1, 16'h1234, 8'h00, 16'h0000, 8'h00);
        m_reset();
        #2;
        chk("rst_RDY",      32'(RDY),        32'd1);
        chk("rst_busy",     32'(dma_busy),   32'd0);
        chk("rst_ack",      32'(dma_ack),    32'd0);
        chk("rst_dma_DI",   32'(dma_DI),     32'd0);
        chk("rst_halt_err", 32'(halt_err),   32'd0);
        chk("rst_stolen",   32'(stolen_cnt), 32'd0);
        @(posedge phi2);
        #1;
        RES = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].req, tbl[i].rw, tbl[i].cab, 8'h00, tbl[i].dab, tbl[i].di);
            #4;
            check_outputs();
            chk($sformatf("tbl%0d_RDY", i),    32'(RDY),        32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i),   32'(dma_busy),   32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_ack", i),    32'(dma_ack),    32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_AB", i),     32'(mem_AB),     32'(tbl[i].e_ab));
            chk($sformatf("tbl%0d_DI", i),     32'(dma_DI),     32'(tbl[i].e_ddi));
            chk($sformatf("tbl%0d_stolen", i), 32'(stolen_cnt), 32'(tbl[i].e_stolen));
            tick();
        end

        // Halt lands on a BRK push: three writes pass through, DMA waits for the next read.
        cycle(1'b1, 1'b1, 16'hC000, 8'h00, 16'h3C10, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wa = 16'h01FD - 16'(i);
            drive(1'b1, 1'b0, wa, 8'h50 + 8'(i), 16'h3C10, 8'h00);
            #4;
            check_outputs();
            chk("brk_AB", 32'(mem_AB), 32'(wa));
            chk("brk_RW", 32'(mem_RW), 32'd0);
            chk("brk_DO", 32'(mem_DO), 32'(8'h50 + 8'(i)));
            tick();
        end
        chk("brk_halt_err_3w", 32'(halt_err), 32'd0);
        cycle(1'b1, 1'b1, 16'hC001, 8'h00, 16'h3C10, 8'h11);
        chk("brk_busy_after_read", 32'(dma_busy), 32'd1);
        cycle(1'b0, 1'b1, 16'hC001, 8'h00, 16'h3C10, 8'h77);
        cycle(1'b0, 1'b1, 16'hC001, 8'h00, 16'h3C10, 8'h00);

        // Four writes while halting raise the sticky error.
        cycle(1'b1, 1'b1, 16'hC002, 8'h00, 16'h3C20, 8'h00);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 16'h01FD - 16'(i), 8'h60, 16'h3C20, 8'h00);
        chk("halt_err_4w", 32'(halt_err), 32'd1);
        cycle(1'b1, 1'b1, 16'hC003, 8'h00, 16'h3C20, 8'h00);
        cycle(1'b0, 1'b1, 16'hC003, 8'h00, 16'h3C20, 8'h33);
        cycle(1'b0, 1'b1, 16'hC003, 8'h00, 16'h3C20, 8'h00);

        // Request withdrawn during HALT: no DMA cycle, RDY back next cycle.
        base = m_stolen;
        cycle(1'b1, 1'b1, 16'hC004, 8'h00, 16'h3C30, 8'h00);
        cycle(1'b0, 1'b1, 16'hC004, 8'h00, 16'h3C30, 8'h00);
        chk("drop_RDY", 32'(RDY), 32'd1);
        cycle(1'b0, 1'b1, 16'hC005, 8'h00, 16'h3C30, 8'h00);
        chk("drop_busy",   32'(dma_busy),   32'd0);
        chk("drop_stolen", 32'(stolen_cnt), base);

        // Continuous request: two full 8-cycle bursts separated by one RDY=1 cycle.
        base = m_stolen;
        rdy_ones = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 16'hD000 + 16'(i), 8'h00, 16'h3D00 + 16'(i), 8'(i));
            #4;
            check_outputs();
            if (RDY) rdy_ones++;
            if (dma_busy) busy_cycles++;
            tick();
        end
        chk("hold_rdy_cycles",  32'(rdy_ones),    32'd2);
        chk("hold_busy_cycles", 32'(busy_cycles), 32'd16);
        chk("hold_stolen",      32'(stolen_cnt),  (base + 16) % 65536);
        cycle(1'b0, 1'b1, 16'hD100, 8'h00, 16'h3D00, 8'h00);

        // Asynchronous reset on the third DMA cycle of a burst.
        cycle(1'b1, 1'b1, 16'h4440, 8'h00, 16'h3E00, 8'h00);
        cycle(1'b1, 1'b1, 16'h4441, 8'h00, 16'h3E00, 8'h00);
        cycle(1'b1, 1'b1, 16'h4442, 8'h00, 16'h3E00, 8'hB0);
        cycle(1'b1, 1'b1, 16'h4443, 8'h00, 16'h3E01, 8'hB1);
        drive(1'b1, 1'b1, 16'h4444, 8'h00, 16'h3E02, 8'hB2);
        #2;
        chk("res_pre_busy", 32'(dma_busy), 32'd1);
        RES = 1'b1;
        #1;
        chk("res_RDY",      32'(RDY),        32'd1);
        chk("res_AB",       32'(mem_AB),     32'h4444);
        chk("res_busy",     32'(dma_busy),   32'd0);
        chk("res_stolen",   32'(stolen_cnt), 32'd0);
        chk("res_halt_err", 32'(halt_err),   32'd0);
        m_reset();
        #1;
        RES = 1'b0;
        tick();
        cycle(1'b1, 1'b1, 16'h4445, 8'h00, 16'h3E03, 8'h00);
        cycle(1'b0, 1'b1, 16'h4445, 8'h00, 16'h3E04, 8'hC4);
        chk("res_regrant_stolen", 32'(stolen_cnt), 32'd1);
        chk("res_regrant_DI",     32'(dma_DI),     32'hC4);
        cycle(1'b0, 1'b1, 16'h4446, 8'h00, 16'h3E04, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
